sync_fifo_ctl: RTL and testbench

Single-clock, parametrised FIFO combining dual-port storage with pointer, level and flag management. It is the general-purpose buffer between the UART receive/transmit datapaths and the user logic on the board clock domain. Depth, width, watermark thresholds and read mode (show-ahead or registered) are all configurable. Overflow and underflow are reported through sticky error flags.

---
 rtl/sync_fifo_ctl.sv | 116 +++++++++++
 tb/tb_sync_fifo_ctl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller: dual-port storage, binary wrap-bit pointers,
// registered level/watermark flags and sticky overflow/underflow reporting.
module sync_fifo_ctl #(
   parameter int unsigned DATASIZE   = 8,
   parameter int unsigned ADDRSIZE   = 4,
   parameter int unsigned AFULL_THR  = 12,
   parameter int unsigned AEMPTY_THR = 2,
   parameter bit          SHOWAHEAD  = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                winc,
   input  logic [DATASIZE-1:0] wdata,
   input  logic                rinc,
   output logic [DATASIZE-1:0] rdata,
   output logic                wfull,
   output logic                rempty,
   output logic                walmost_full,
   output logic                ralmost_empty,
   output logic [ADDRSIZE:0]   level,
   output logic                overflow,
   output logic                underflow,
   input  logic                clr_err
);

   localparam int unsigned       DEPTH    = 1 << ADDRSIZE;
   localparam logic [ADDRSIZE:0] DEPTH_V  = (ADDRSIZE+1)'(DEPTH);
   localparam logic [ADDRSIZE:0] AFULL_V  = (ADDRSIZE+1)'(AFULL_THR);
   localparam logic [ADDRSIZE:0] AEMPTY_V = (ADDRSIZE+1)'(AEMPTY_THR);
   localparam logic [ADDRSIZE:0] ZERO_V   = '0;

   logic [DATASIZE-1:0] mem [DEPTH];

   logic [ADDRSIZE:0] wptr_q, wptr_d;
   logic [ADDRSIZE:0] rptr_q, rptr_d;
   logic [ADDRSIZE:0] level_cur, level_next;
   logic              wfull_q, wfull_d;
   logic              rempty_q, rempty_d;
   logic              afull_q, afull_d;
   logic              aempty_q, aempty_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              we, re;

   // Occupancy is the wrap-aware pointer difference, so no separate level
   // register is needed and it can never drift from the pointers.
   always_comb begin
      we         = winc & ~wfull_q;
      re         = rinc & ~rempty_q;
      wptr_d     = wptr_q + {ZERO_V[ADDRSIZE:1], we};
      rptr_d     = rptr_q + {ZERO_V[ADDRSIZE:1], re};
      level_cur  = wptr_q - rptr_q;
      level_next = level_cur + {ZERO_V[ADDRSIZE:1], we} - {ZERO_V[ADDRSIZE:1], re};
      wfull_d    = (level_next == DEPTH_V);
      rempty_d   = (level_next == ZERO_V);
      afull_d    = (level_next >= AFULL_V);
      aempty_d   = (level_next <= AEMPTY_V);
      ovf_d      = (winc & wfull_q)  | (ovf_q & ~clr_err);
      unf_d      = (rinc & rempty_q) | (unf_q & ~clr_err);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         wfull_q  <= 1'b0;
         rempty_q <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         wfull_q  <= wfull_d;
         rempty_q <= rempty_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[wptr_q[ADDRSIZE-1:0]] <= wdata;
   end

   generate
      if (SHOWAHEAD) begin : g_fwft
         assign rdata = mem[rptr_q[ADDRSIZE-1:0]];
      end else begin : g_reg
         logic [DATASIZE-1:0] rdata_q, rdata_d;

         always_comb begin
            rdata_d = rdata_q;
            if (re) rdata_d = mem[rptr_q[ADDRSIZE-1:0]];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) rdata_q <= '0;
            else        rdata_q <= rdata_d;
         end

         assign rdata = rdata_q;
      end
   endgenerate

   assign wfull         = wfull_q;
   assign rempty        = rempty_q;
   assign walmost_full  = afull_q;
   assign ralmost_empty = aempty_q;
   assign level         = level_cur;
   assign overflow      = ovf_q;
   assign underflow     = unf_q;

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Scoreboard bench for sync_fifo_ctl: one show-ahead and one registered-read
// instance share stimulus; a queue model predicts level, flags and data.
module tb_sync_fifo_ctl;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       winc = 1'b0, rinc = 1'b0, clr_err = 1'b0;
   logic [7:0] wdata = '0;

   logic [7:0] rdata1, rdata0;
   logic       wfull1, rempty1, afull1, aempty1, ovf1, unf1;
   logic       wfull0, rempty0, afull0, aempty0, ovf0, unf0;
   logic [4:0] level1, level0;

   sync_fifo_ctl #(.DATASIZE(8), .ADDRSIZE(4), .AFULL_THR(12), .AEMPTY_THR(2), .SHOWAHEAD(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rdata1),
      .wfull(wfull1), .rempty(rempty1), .walmost_full(afull1), .ralmost_empty(aempty1),
      .level(level1), .overflow(ovf1), .underflow(unf1), .clr_err(clr_err));

   sync_fifo_ctl #(.DATASIZE(8), .ADDRSIZE(4), .AFULL_THR(12), .AEMPTY_THR(2), .SHOWAHEAD(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rdata0),
      .wfull(wfull0), .rempty(rempty0), .walmost_full(afull0), .ralmost_empty(aempty0),
      .level(level0), .overflow(ovf0), .underflow(unf0), .clr_err(clr_err));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [7:0] mq[$];
   logic [7:0] exp1[$];
   logic [7:0] exp0[$];
   bit         m_ovf = 1'b0, m_unf = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_state(input string tag);
      int n;
      n = mq.size();
      chk({tag, " level"},         level1,  n);
      chk({tag, " wfull"},         wfull1,  (n == DEPTH));
      chk({tag, " rempty"},        rempty1, (n == 0));
      chk({tag, " walmost_full"},  afull1,  (n >= 12));
      chk({tag, " ralmost_empty"}, aempty1, (n <= 2));
      chk({tag, " overflow"},      ovf1,    m_ovf);
      chk({tag, " underflow"},     unf1,    m_unf);
      chk({tag, " reg level"},     level0,  n);
      chk({tag, " reg flags"},     {wfull0, rempty0, afull0, aempty0, ovf0, unf0},
          {(n == DEPTH), (n == 0), (n >= 12), (n <= 2), m_ovf, m_unf});
   endtask

   task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c);
      bit full_m, empty_m;
      @(negedge clk);
      winc = w; wdata = d; rinc = r; clr_err = c;
      full_m  = (mq.size() == DEPTH);
      empty_m = (mq.size() == 0);
      m_ovf = (w && full_m)  || (m_ovf && !c);
      m_unf = (r && empty_m) || (m_unf && !c);
      if (r && !empty_m) void'(mq.pop_front());
      if (w && !full_m) begin
         mq.push_back(d);
         exp1.push_back(d);
         exp0.push_back(d);
      end
      @(posedge clk);
      #1;
      check_state("step");
   endtask

   task automatic model_reset();
      mq.delete(); exp1.delete(); exp0.delete();
      m_ovf = 1'b0; m_unf = 1'b0;
   endtask

   // Monitor: data checks driven purely by what the DUTs present.
   bit         pend = 1'b0;
   logic [7:0] last = '0;
   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         pend = 1'b0;
         last = '0;
      end else begin
         if (!rempty1) begin
            if (exp1.size() == 0) chk("fwft scoreboard underrun", 1, 0);
            else begin
               chk("fwft rdata", rdata1, exp1[0]);
               if (rinc) void'(exp1.pop_front());
            end
         end
         if (pend) begin
            if (exp0.size() == 0) chk("reg scoreboard underrun", 1, 0);
            else last = exp0.pop_front();
         end
         chk("reg rdata", rdata0, last);
         pend = rinc && !rempty0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int pw, pr;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check_state("reset");
      chk("reset reg rdata", rdata0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
      step(1, 8'hAA, 0, 0);
      step(1, 8'hBB, 1, 0);
      repeat (15) step(0, 8'h00, 1, 0);
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 0, 1);

      for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0, 0);
      step(1, 8'hCC, 0, 1);
      step(0, 8'h00, 0, 1);
      repeat (16) step(0, 8'h00, 1, 0);

      step(1, 8'h77, 1, 0);
      for (int i = 0; i < 4; i++) step(1, 8'(8'h80 + i), 0, 0);
      for (int i = 0; i < 40; i++) step(1, 8'(8'h90 + i), 1, 0);
      repeat (5) step(0, 8'h00, 1, 0);

      step(1, 8'h3C, 0, 0);
      step(1, 8'h5A, 0, 0);
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 0, 0);
      step(0, 8'h00, 0, 1);

      for (int i = 0; i < 7; i++) step(1, 8'(8'h10 + i), 0, 0);
      @(negedge clk);
      winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_state("midreset");
      chk("midreset reg rdata", rdata0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 8'hE5, 0, 0);
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 0, 0);

      for (int seg = 0; seg < 8; seg++) begin
         pw = (seg % 2 == 0) ? 80 : 30;
         pr = (seg % 2 == 0) ? 30 : 80;
         for (int i = 0; i < 50; i++)
            step($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
                 $urandom_range(0, 15) == 0);
      end

      @(negedge clk);
      winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
